// File: rtl/fx_pkg.sv
// ----------------------------------------------------------------------------
// fx_pkg
// Shared types and constants for the delay-line effects datapath.
//   sched_state_t : slot schedule of the delay-memory scheduler
//   SAMPLE_W      : ADC sample width
//   DATA_W        : delay-memory word width
//   DEF_*         : default buffer size and tap delays
// ----------------------------------------------------------------------------
package fx_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned DATA_W   = 16;

  localparam int unsigned DEF_ADDR_W       = 12;
  localparam int unsigned DEF_CHORUS_BASE  = 256;
  localparam int unsigned DEF_CHORUS_DEPTH = 128;
  localparam int unsigned DEF_REVERB_DELAY = 2048;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_CHOR_RD = 3'd2,
    S_REV_RD  = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } sched_state_t;

  // Zero-extend an ADC sample to a memory word.
  function automatic logic [DATA_W-1:0] widen_sample(input logic [SAMPLE_W-1:0] s);
    return {{(DATA_W-SAMPLE_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/chorus_lfo.sv
// ----------------------------------------------------------------------------
// chorus_lfo
// Triangle counter sweeping 0 .. DEPTH-1 and back, one step per enabled pulse.
// Holds its value while step_i is low.
//   clk, reset : clock, synchronous active-high reset (value 0, direction up)
//   step_i     : advance the triangle by one position
//   lfo_o      : current offset added to the chorus base delay
// ----------------------------------------------------------------------------
module chorus_lfo
  import fx_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_CHORUS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_i,
  output logic [ADDR_W-1:0] lfo_o
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] lfo_q, lfo_d;
  logic              dir_down_q, dir_down_d;

  // Step with reflection at both ends so each endpoint appears once per sweep.
  always_comb begin
    lfo_d      = lfo_q;
    dir_down_d = dir_down_q;
    if (step_i && (DEPTH > 1)) begin
      if (!dir_down_q) begin
        if (lfo_q == TOP) begin
          dir_down_d = 1'b1;
          lfo_d      = lfo_q - 1'b1;
        end else begin
          lfo_d      = lfo_q + 1'b1;
        end
      end else begin
        if (lfo_q == '0) begin
          dir_down_d = 1'b0;
          lfo_d      = lfo_q + 1'b1;
        end else begin
          lfo_d      = lfo_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfo_q      <= '0;
      dir_down_q <= 1'b0;
    end else begin
      lfo_q      <= lfo_d;
      dir_down_q <= dir_down_d;
    end
  end

  assign lfo_o = lfo_q;

endmodule

// File: rtl/delay_mem_scheduler.sv
// ----------------------------------------------------------------------------
// delay_mem_scheduler
// Fixed per-sample slot schedule for the shared delay-line memory:
// write the new sample, read the chorus tap, read the reverb tap, capture,
// then present all three samples with a one-cycle valid pulse.
//   clk, reset        : clock, synchronous active-high reset
//   start_sample      : one-cycle pulse opening a sample period
//   sample_in         : ADC word, latched with start_sample
//   chorus_on/reverb_on : effect enables, latched with start_sample
//   mem_addr/mem_we/mem_wdata : memory command (combinational from state)
//   mem_rdata         : synchronous-read data, one cycle after the address
//   main/chorus/reverb_sample : captured output samples
//   samples_valid     : one-cycle pulse when all three outputs are current
//   busy              : schedule in progress (WRITE .. DONE)
//   overrun           : start_sample arrived while busy and was dropped
// ----------------------------------------------------------------------------
module delay_mem_scheduler
  import fx_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned CHORUS_BASE  = DEF_CHORUS_BASE,
  parameter int unsigned CHORUS_DEPTH = DEF_CHORUS_DEPTH,
  parameter int unsigned REVERB_DELAY = DEF_REVERB_DELAY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_sample,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                chorus_on,
  input  logic                reverb_on,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   main_sample,
  output logic [DATA_W-1:0]   chorus_sample,
  output logic [DATA_W-1:0]   reverb_sample,
  output logic                samples_valid,
  output logic                busy,
  output logic                overrun
);

  localparam logic [ADDR_W-1:0] CHORUS_BASE_A  = ADDR_W'(CHORUS_BASE);
  localparam logic [ADDR_W-1:0] REVERB_DELAY_A = ADDR_W'(REVERB_DELAY);

  sched_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                chor_en_q;
  logic                rev_en_q;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic [DATA_W-1:0]   main_q, chorus_q, reverb_q;
  logic                valid_q, busy_q, overrun_q;

  logic [ADDR_W-1:0]   lfo;
  logic [ADDR_W-1:0]   chor_addr, rev_addr;
  logic                lfo_step;

  // Tap addresses: natural modulo-2^ADDR_W subtraction handles buffer wrap.
  assign chor_addr = wr_ptr_q - CHORUS_BASE_A - lfo;
  assign rev_addr  = wr_ptr_q - REVERB_DELAY_A;

  // LFO advances once per completed sample, only while chorus is active.
  assign lfo_step = (state_q == S_DONE) && chor_en_q;

  chorus_lfo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (CHORUS_DEPTH)
  ) u_lfo (
    .clk    (clk),
    .reset  (reset),
    .step_i (lfo_step),
    .lfo_o  (lfo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fixed slot order regardless of effect enables.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_sample) state_d = S_WRITE;
      S_WRITE:   state_d = S_CHOR_RD;
      S_CHOR_RD: state_d = S_REV_RD;
      S_REV_RD:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Memory command decode; the address holds when a slot makes no access.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_hold_q;
    mem_wdata = widen_sample(sample_q);
    unique case (state_q)
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = wr_ptr_q;
      end
      S_CHOR_RD: if (chor_en_q) mem_addr = chor_addr;
      S_REV_RD:  if (rev_en_q)  mem_addr = rev_addr;
      default: ;
    endcase
  end

  // Datapath: latches, pointer, capture registers and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      sample_q    <= '0;
      chor_en_q   <= 1'b0;
      rev_en_q    <= 1'b0;
      addr_hold_q <= '0;
      main_q      <= '0;
      chorus_q    <= '0;
      reverb_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      addr_hold_q <= mem_addr;
      valid_q     <= (state_q == S_CAPTURE);
      busy_q      <= (state_d != S_IDLE);
      overrun_q   <= start_sample && (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (start_sample) begin
            sample_q  <= sample_in;
            chor_en_q <= chorus_on;
            rev_en_q  <= reverb_on;
          end
        end
        S_WRITE:   main_q   <= widen_sample(sample_q);
        S_REV_RD:  chorus_q <= chor_en_q ? mem_rdata : '0;
        S_CAPTURE: reverb_q <= rev_en_q ? mem_rdata : '0;
        S_DONE:    wr_ptr_q <= wr_ptr_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign main_sample   = main_q;
  assign chorus_sample = chorus_q;
  assign reverb_sample = reverb_q;
  assign samples_valid = valid_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_delay_mem_scheduler.sv
// ----------------------------------------------------------------------------
// tb_delay_mem_scheduler
// Drives sample periods into delay_mem_scheduler against a behavioural RAM and
// checks every cycle against a per-sample expectation computed from the
// buffer/tap rules, plus literal checks pinning the model.
// ----------------------------------------------------------------------------
module tb_delay_mem_scheduler;
  import fx_pkg::*;

  localparam int AW   = 12;
  localparam int MASK = 4095;
  localparam int BASE = 256;
  localparam int D    = 128;
  localparam int RD   = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_sample;
  logic [11:0] sample_in;
  logic        chorus_on, reverb_on;
  logic [AW-1:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] main_sample, chorus_sample, reverb_sample;
  logic        samples_valid, busy, overrun;

  delay_mem_scheduler #(
    .ADDR_W(AW), .CHORUS_BASE(BASE), .CHORUS_DEPTH(D), .REVERB_DELAY(RD)
  ) dut (
    .clk(clk), .reset(reset), .start_sample(start_sample), .sample_in(sample_in),
    .chorus_on(chorus_on), .reverb_on(reverb_on), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .main_sample(main_sample), .chorus_sample(chorus_sample),
    .reverb_sample(reverb_sample), .samples_valid(samples_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read delay memory, preloaded with a recognisable pattern.
  logic [15:0] ram  [0:4095];
  logic [15:0] mmem [0:4095];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: write position, number of LFO steps taken, one sample in flight.
  int  mwr = 0, msteps = 0;
  bit  pend = 0;
  int  acc = 0, ovr_at = -1;
  int  e_wr, e_a2, e_a3;
  logic [15:0] e_main, e_ch, e_rv;

  // Triangle position after n steps: period 2D-2.
  function automatic int lfo_at(input int n);
    int p;
    p = n % (2*D - 2);
    return (p < D) ? p : (2*D - 2 - p);
  endfunction

  // Observed DUT values per sample, for literal checks.
  int obs_wr, obs_a2, obs_a3;
  logic [15:0] obs_wdata, obs_main, obs_ch, obs_rv;
  int nvalid = 0;
  bit chk_en = 0;
  bit in_win;

  // Per-cycle comparison against the expected schedule of the sample in flight.
  always @(negedge clk) begin
    if (chk_en) begin
      in_win = pend && (cyc >= acc + 1) && (cyc <= acc + 5);
      chk("mem_we",        32'(mem_we),        32'(pend && cyc == acc + 1));
      chk("samples_valid", 32'(samples_valid), 32'(pend && cyc == acc + 5));
      chk("busy",          32'(busy),          32'(in_win));
      chk("overrun",       32'(overrun),       32'(cyc == ovr_at));
      if (samples_valid) nvalid++;
      if (pend && cyc == acc + 1) begin
        obs_wr = 32'(mem_addr); obs_wdata = mem_wdata;
        chk("write_addr",  32'(mem_addr),  e_wr);
        chk("write_data",  32'(mem_wdata), 32'(e_main));
      end
      if (pend && cyc == acc + 2) begin
        obs_a2 = 32'(mem_addr);
        chk("chorus_slot_addr", 32'(mem_addr), e_a2);
      end
      if (pend && cyc == acc + 3) begin
        obs_a3 = 32'(mem_addr);
        chk("reverb_slot_addr", 32'(mem_addr), e_a3);
      end
      if (pend && cyc == acc + 5) begin
        obs_main = main_sample; obs_ch = chorus_sample; obs_rv = reverb_sample;
        chk("main_sample",   32'(main_sample),   32'(e_main));
        chk("chorus_sample", 32'(chorus_sample), 32'(e_ch));
        chk("reverb_sample", 32'(reverb_sample), 32'(e_rv));
      end
    end
  end

  task automatic model_reset();
    pend = 0; mwr = 0; msteps = 0;
  endtask

  // Entered and left at a negedge; one sample period of 6 cycles.
  // mode 0: normal, 1: extra start pulse in cycle 3, 2: reset in cycle 2.
  task automatic do_sample(input logic [11:0] s, input bit ch, input bit rv, input int mode);
    int ca, ra;
    acc = cyc; pend = 1;
    start_sample = 1'b1; sample_in = s; chorus_on = ch; reverb_on = rv;
    e_wr = mwr;
    mmem[mwr] = {4'b0, s};
    ca = (mwr - BASE - lfo_at(msteps)) & MASK;
    ra = (mwr - RD) & MASK;
    e_main = {4'b0, s};
    e_ch   = ch ? mmem[ca] : 16'h0;
    e_rv   = rv ? mmem[ra] : 16'h0;
    e_a2   = ch ? ca : mwr;
    e_a3   = rv ? ra : e_a2;
    mwr = (mwr + 1) & MASK;
    if (ch) msteps++;
    @(negedge clk);                         // cycle 1
    start_sample = 1'b0; sample_in = 12'h0;
    chorus_on = ~ch; reverb_on = ~rv;       // enables must already be latched
    @(negedge clk);                         // cycle 2
    if (mode == 2) begin
      reset = 1'b1;
      @(posedge clk);
      #1 model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      @(negedge clk);                       // cycle 3
      if (mode == 1) begin
        start_sample = 1'b1; sample_in = 12'hFFF; ovr_at = acc + 4;
      end
      @(negedge clk);                       // cycle 4
      start_sample = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk);
    #1 model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int a = 0; a < 4096; a++) begin
      ram[a]  <= 16'hA000 | 16'(a);
      mmem[a]  = 16'hA000 | 16'(a);
    end
    reset = 1'b1; start_sample = 1'b0; sample_in = 12'h0;
    chorus_on = 1'b0; reverb_on = 1'b0;
    repeat (2) @(negedge clk);
    start_sample = 1'b1; sample_in = 12'h777;   // coincident with reset
    @(negedge clk);
    start_sample = 1'b0; reset = 1'b0;
    chk("reset_mem_we",   32'(mem_we),        0);
    chk("reset_mem_addr", 32'(mem_addr),      0);
    chk("reset_main",     32'(main_sample),   0);
    chk("reset_chorus",   32'(chorus_sample), 0);
    chk("reset_reverb",   32'(reverb_sample), 0);
    chk("reset_valid",    32'(samples_valid), 0);
    chk("reset_busy",     32'(busy),          0);
    chk("reset_overrun",  32'(overrun),       0);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);

    // Basic write/capture, effects off.
    do_sample(12'h123, 0, 0, 0);
    chk("t1_write_addr", obs_wr, 0);
    chk("t1_wdata",  32'(obs_wdata), 32'h0123);
    chk("t1_main",   32'(obs_main),  32'h0123);
    chk("t1_chorus", 32'(obs_ch),    0);
    chk("t1_reverb", 32'(obs_rv),    0);
    do_sample(12'h456, 0, 0, 0);
    chk("t1_next_write_addr", obs_wr, 1);

    // Overrun: second start mid-schedule is dropped.
    n0 = nvalid;
    do_sample(12'h2AB, 1, 1, 1);
    chk("overrun_valid_count", nvalid - n0, 1);

    // Reset in cycle 2 aborts the sample.
    n0 = nvalid;
    do_sample(12'h3CD, 1, 0, 2);
    chk("abort_valid_count", nvalid - n0, 0);
    chk("abort_main",   32'(main_sample),   0);
    chk("abort_chorus", 32'(chorus_sample), 0);
    chk("abort_reverb", 32'(reverb_sample), 0);
    chk("abort_mem_we", 32'(mem_we),        0);
    do_sample(12'h111, 0, 0, 0);
    chk("abort_next_write_addr", obs_wr, 0);

    // Ramp through a full buffer wrap with reverb on.
    reset_dut();
    for (int k = 0; k <= 4106; k++) begin
      do_sample(12'(k & MASK), (k == 4106), 1, 0);
      if (k == 0) begin
        chk("ramp0_rev_addr", obs_a3, 2048);
        chk("ramp0_reverb",   32'(obs_rv), 32'hA800);
      end
      if (k == 2100) begin
        chk("ramp2100_rev_addr", obs_a3, 52);
        chk("ramp2100_reverb",   32'(obs_rv), 52);
      end
      if (k == 4096) begin
        chk("wrap_write_addr", obs_wr, 0);
        chk("wrap_rev_addr",   obs_a3, 2048);
        chk("wrap_reverb",     32'(obs_rv), 32'h0800);
      end
      if (k == 4106) begin
        chk("wrap_chorus_addr", obs_a2, 3850);
        chk("wrap_chorus",      32'(obs_ch), 32'h0F0A);
      end
    end

    // LFO sweep, then hold while chorus is off.
    reset_dut();
    for (int j = 0; j <= 306; j++) begin
      int dly;
      do_sample(12'(j & MASK), !(j >= 300 && j < 305), 0, 0);
      dly = (obs_wr - obs_a2) & MASK;
      if (j == 0)   chk("lfo_delay_j0",   dly, 256);
      if (j == 127) chk("lfo_delay_j127", dly, 383);
      if (j == 128) chk("lfo_delay_j128", dly, 382);
      if (j == 254) chk("lfo_delay_j254", dly, 256);
      if (j == 255) chk("lfo_delay_j255", dly, 257);
      if (j == 305) chk("lfo_delay_hold", dly, 302);
      if (j == 306) chk("lfo_delay_resume", dly, 303);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
